// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: holds dispatched micro-ops, wakes them through broadcast
// update ports and issues the oldest fully ready entry, with rollback squash by ROB id.
module age_issue_queue #(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 248,
  parameter int COND_WIDTH    = 2,
  parameter int ROB_IDX_WIDTH = 6,
  parameter int NUM_UPD       = 2
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   enq_valid,
  output logic                                   enq_ready,
  input  logic [DATA_WIDTH-1:0]                  enq_data,
  input  logic [ROB_IDX_WIDTH:0]                 enq_robid,
  input  logic [COND_WIDTH-1:0]                  enq_condition,
  output logic                                   deq_valid,
  input  logic                                   deq_ready,
  output logic [DATA_WIDTH-1:0]                  deq_data,
  output logic [ROB_IDX_WIDTH:0]                 deq_robid,
  input  logic [NUM_UPD-1:0]                     update_valid,
  input  logic [NUM_UPD*(ROB_IDX_WIDTH+1)-1:0]   update_robid,
  input  logic [NUM_UPD*COND_WIDTH-1:0]          update_mask,
  input  logic [NUM_UPD*COND_WIDTH-1:0]          update_in,
  input  logic                                   flush_valid,
  input  logic [ROB_IDX_WIDTH:0]                 flush_robid,
  output logic [$clog2(DEPTH+1)-1:0]             count,
  output logic [DEPTH-1:0]                       entry_valid
);

  localparam int RW = ROB_IDX_WIDTH + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] data_reg [DEPTH];
  logic [RW-1:0]         robid_reg [DEPTH];
  logic [COND_WIDTH-1:0] cond_reg [DEPTH];
  logic [COND_WIDTH-1:0] cond_next [DEPTH];
  logic [DEPTH-1:0]      age_reg [DEPTH];
  logic [DEPTH-1:0]      age_next [DEPTH];
  logic [CW-1:0]         count_reg, count_next;

  logic [DEPTH-1:0]      ready, select, squash, alloc, removed;
  logic [COND_WIDTH-1:0] enq_cond;
  logic                  enq_fire, deq_fire;

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DEPTH-1:0] older;
      for (gj = 0; gj < DEPTH; gj++) begin : g_col
        assign older[gj] = age_reg[gj][gi];
      end
      assign ready[gi]  = valid_reg[gi] & (&cond_reg[gi]);
      // An older entry only blocks selection when it is itself ready.
      assign select[gi] = ready[gi] & ~|(older & ready);
      // Wrap-bit compare: a differing wrap bit inverts the index ordering.
      assign squash[gi] = valid_reg[gi] & (flush_robid[RW-1] ^ robid_reg[gi][RW-1] ^
                          (flush_robid[RW-2:0] < robid_reg[gi][RW-2:0]));
    end
  endgenerate

  assign enq_ready   = (count_reg < CW'(DEPTH)) & ~flush_valid;
  assign deq_valid   = (|ready) & ~flush_valid;
  assign enq_fire    = enq_valid & enq_ready;
  assign deq_fire    = deq_valid & deq_ready;
  assign removed     = (deq_fire ? select : '0) | (flush_valid ? squash : '0);
  assign count       = count_reg;
  assign entry_valid = valid_reg;

  always_comb begin
    deq_data  = '0;
    deq_robid = '0;
    if (deq_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (select[i]) begin
          deq_data  = deq_data | data_reg[i];
          deq_robid = deq_robid | robid_reg[i];
        end
      end
    end
  end

  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_reg[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Higher-numbered ports are applied last so they win on overlapping bits.
  always_comb begin
    enq_cond = enq_condition;
    for (int p = 0; p < NUM_UPD; p++) begin
      if (update_valid[p] && update_robid[p*RW +: RW] == enq_robid) begin
        enq_cond = (enq_cond & ~update_mask[p*COND_WIDTH +: COND_WIDTH]) |
                   (update_in[p*COND_WIDTH +: COND_WIDTH] & update_mask[p*COND_WIDTH +: COND_WIDTH]);
      end
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cond_next[e] = cond_reg[e];
      for (int p = 0; p < NUM_UPD; p++) begin
        if (update_valid[p] && valid_reg[e] && update_robid[p*RW +: RW] == robid_reg[e]) begin
          cond_next[e] = (cond_next[e] & ~update_mask[p*COND_WIDTH +: COND_WIDTH]) |
                         (update_in[p*COND_WIDTH +: COND_WIDTH] & update_mask[p*COND_WIDTH +: COND_WIDTH]);
        end
      end
      if (enq_fire && alloc[e]) begin
        cond_next[e] = enq_cond;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_next[k] = age_reg[k];
    end
    if (enq_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          age_next[k] = '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != k) age_next[j][k] = valid_reg[j];
          end
        end
      end
    end
    // Removal runs last so an entry leaving this cycle never stays marked older.
    for (int k = 0; k < DEPTH; k++) begin
      if (removed[k]) begin
        age_next[k] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          age_next[j][k] = 1'b0;
        end
      end
    end
  end

  assign valid_next = (valid_reg & ~removed) | (enq_fire ? alloc : '0);
  assign count_next = count_reg + CW'(enq_fire) - CW'(deq_fire) -
                      CW'($countones(flush_valid ? squash : '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i]  <= '0;
        robid_reg[i] <= '0;
        cond_reg[i]  <= '0;
        age_reg[i]   <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        cond_reg[i] <= cond_next[i];
        age_reg[i]  <= age_next[i];
        if (enq_fire && alloc[i]) begin
          data_reg[i]  <= enq_data;
          robid_reg[i] <= enq_robid;
        end
      end
    end
  end

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue: an ordered-list model predicts outputs every cycle,
// with literal checks pinning the directed scenarios.
module tb_age_issue_queue;

  localparam int DEPTH = 8;
  localparam int DW    = 248;
  localparam int CDW   = 2;
  localparam int RIW   = 6;
  localparam int NU    = 2;
  localparam int RW    = RIW + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic               clock;
  logic               reset_n;
  logic               enq_valid;
  logic               enq_ready;
  logic [DW-1:0]      enq_data;
  logic [RW-1:0]      enq_robid;
  logic [CDW-1:0]     enq_condition;
  logic               deq_valid;
  logic               deq_ready;
  logic [DW-1:0]      deq_data;
  logic [RW-1:0]      deq_robid;
  logic [NU-1:0]      update_valid;
  logic [NU*RW-1:0]   update_robid;
  logic [NU*CDW-1:0]  update_mask;
  logic [NU*CDW-1:0]  update_in;
  logic               flush_valid;
  logic [RW-1:0]      flush_robid;
  logic [CW-1:0]      count;
  logic [DEPTH-1:0]   entry_valid;

  age_issue_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .COND_WIDTH(CDW), .ROB_IDX_WIDTH(RIW), .NUM_UPD(NU)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_robid(enq_robid), .enq_condition(enq_condition),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_robid(deq_robid),
    .update_valid(update_valid), .update_robid(update_robid),
    .update_mask(update_mask), .update_in(update_in),
    .flush_valid(flush_valid), .flush_robid(flush_robid),
    .count(count), .entry_valid(entry_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [RW-1:0] r);
    logic [DW-1:0] d;
    d = '0;
    d[RW-1:0] = r;
    d[DW-1 -: 8] = 8'({1'b0, r} ^ 8'h5A);
    d[128 +: 16] = {r, 9'h1A5};
    return d;
  endfunction

  // Model: entries kept oldest-first; each remembers which slot it occupies.
  typedef struct {
    logic [RW-1:0]  robid;
    logic [CDW-1:0] cond;
    logic [DW-1:0]  data;
    int             slot;
  } ent_t;

  ent_t mq[$];
  ent_t nq[$];
  ent_t ne;

  function automatic logic [CDW-1:0] apply_upd(input logic [RW-1:0] r, input logic [CDW-1:0] c);
    logic [CDW-1:0] v;
    v = c;
    for (int p = 0; p < NU; p++) begin
      if (update_valid[p] && update_robid[p*RW +: RW] == r) begin
        for (int b = 0; b < CDW; b++) begin
          if (update_mask[p*CDW + b]) v[b] = update_in[p*CDW + b];
        end
      end
    end
    return v;
  endfunction

  // Younger means the forward distance from the flush point is 1..half the id space.
  function automatic bit is_younger(input logic [RW-1:0] r, input logic [RW-1:0] f);
    logic [RW-1:0] d;
    d = r - f;
    return (d >= 1) && (int'(d) <= (1 << RIW));
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].cond == {CDW{1'b1}}) return i;
    end
    return -1;
  endfunction

  function automatic int lowest_free();
    bit used [DEPTH];
    for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
    foreach (mq[i]) used[mq[i].slot] = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (!used[i]) return i;
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else begin
      int  sel;
      bit  fire_deq, fire_enq;
      sel      = first_ready();
      fire_deq = deq_ready && !flush_valid && (sel >= 0);
      fire_enq = enq_valid && !flush_valid && (mq.size() < DEPTH);
      nq.delete();
      for (int i = 0; i < mq.size(); i++) begin
        ne = mq[i];
        ne.cond = apply_upd(ne.robid, ne.cond);
        if (fire_deq && i == sel) continue;
        if (flush_valid && is_younger(ne.robid, flush_robid)) continue;
        nq.push_back(ne);
      end
      if (fire_enq) begin
        ne.robid = enq_robid;
        ne.cond  = apply_upd(enq_robid, enq_condition);
        ne.data  = enq_data;
        ne.slot  = lowest_free();
        nq.push_back(ne);
      end
      mq = nq;
    end
  end

  always @(negedge clock) begin
    int            sel;
    logic [DEPTH-1:0] ev;
    bit            dv;
    sel = first_ready();
    dv  = (sel >= 0) && !flush_valid;
    ev  = '0;
    foreach (mq[i]) ev[mq[i].slot] = 1'b1;
    chk("count", 256'(count), 256'(mq.size()));
    chk("entry_valid", 256'(entry_valid), 256'(ev));
    chk("enq_ready", 256'(enq_ready), 256'((mq.size() < DEPTH) && !flush_valid));
    chk("deq_valid", 256'(deq_valid), 256'(dv));
    chk("deq_robid", 256'(deq_robid), dv ? 256'(mq[sel].robid) : 256'(0));
    chk("deq_data", 256'(deq_data), dv ? 256'(mq[sel].data) : 256'(0));
  end

  task automatic clr();
    enq_valid = 0; enq_data = '0; enq_robid = '0; enq_condition = '0;
    deq_ready = 0; update_valid = '0; update_robid = '0; update_mask = '0; update_in = '0;
    flush_valid = 0; flush_robid = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clr();
    #1;
  endtask

  task automatic set_enq(input logic [RW-1:0] r, input logic [CDW-1:0] c);
    enq_valid = 1; enq_robid = r; enq_condition = c; enq_data = mkdata(r);
  endtask

  task automatic set_upd(input int p, input logic [RW-1:0] r, input logic [CDW-1:0] m, input logic [CDW-1:0] v);
    update_valid[p] = 1'b1;
    update_robid[p*RW +: RW] = r;
    update_mask[p*CDW +: CDW] = m;
    update_in[p*CDW +: CDW] = v;
  endtask

  initial begin
    clr();
    reset_n = 1;
    #1 reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst count", 256'(count), 256'(0));
    chk("rst enq_ready", 256'(enq_ready), 256'(1));
    chk("rst deq_valid", 256'(deq_valid), 256'(0));
    chk("rst deq_robid", 256'(deq_robid), 256'(0));
    chk("rst entry_valid", 256'(entry_valid), 256'(0));
    reset_n = 1;
    step();

    // In-order issue of three ready entries
    set_enq(7'd3, 2'b11); step();
    set_enq(7'd4, 2'b11); step();
    set_enq(7'd5, 2'b11); step();
    chk("order count3", 256'(count), 256'(3));
    for (int i = 0; i < 3; i++) begin
      deq_ready = 1; #1;
      chk("order robid", 256'(deq_robid), 256'(3 + i));
      step();
    end
    chk("order count0", 256'(count), 256'(0));

    // Younger ready entry passes a non-ready older one
    set_enq(7'd10, 2'b00); step();
    set_enq(7'd11, 2'b11); step();
    chk("ooo first", 256'(deq_robid), 256'(11));
    deq_ready = 1; step();
    chk("ooo none", 256'(deq_valid), 256'(0));
    set_upd(0, 7'd10, 2'b11, 2'b11); step();
    chk("ooo wake", 256'(deq_robid), 256'(10));
    deq_ready = 1; step();

    // Same-cycle bypass completes the enqueued condition
    set_enq(7'd7, 2'b01); set_upd(1, 7'd7, 2'b10, 2'b10); step();
    chk("bypass valid", 256'(deq_valid), 256'(1));
    chk("bypass robid", 256'(deq_robid), 256'(7));
    deq_ready = 1; step();

    // Port 1 overrides port 0 on the same bit
    set_enq(7'd20, 2'b10); step();
    set_upd(0, 7'd20, 2'b01, 2'b01); set_upd(1, 7'd20, 2'b01, 2'b00); step();
    chk("prio bit0", 256'(deq_valid), 256'(0));
    set_upd(0, 7'd20, 2'b01, 2'b01); step();
    chk("prio wake", 256'(deq_robid), 256'(20));
    deq_ready = 1; step();

    // Flush across the wrap boundary
    set_enq(7'h3E, 2'b11); step();
    set_enq(7'h3F, 2'b11); step();
    set_enq(7'h40, 2'b11); step();
    set_enq(7'h41, 2'b11); step();
    flush_valid = 1; flush_robid = 7'h3F; set_enq(7'h50, 2'b11); deq_ready = 1; #1;
    chk("flush enq_ready", 256'(enq_ready), 256'(0));
    chk("flush deq_valid", 256'(deq_valid), 256'(0));
    step();
    chk("flush count", 256'(count), 256'(2));
    chk("flush slots", 256'(entry_valid), 256'(8'b0000_0011));
    chk("flush oldest", 256'(deq_robid), 256'(7'h3E));
    deq_ready = 1; step();
    deq_ready = 1; step();

    // Full queue, then recover a slot and refill it
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(7'(8'h60 + i), 2'b00); step();
    end
    chk("full count", 256'(count), 256'(8));
    chk("full enq_ready", 256'(enq_ready), 256'(0));
    set_enq(7'h68, 2'b11); deq_ready = 1; step();
    chk("full hold", 256'(count), 256'(8));
    set_upd(0, 7'h62, 2'b11, 2'b11); step();
    chk("full ready62", 256'(deq_robid), 256'(7'h62));
    set_enq(7'h69, 2'b11); deq_ready = 1; #1;
    chk("full deq no enq", 256'(enq_ready), 256'(0));
    step();
    chk("full count7", 256'(count), 256'(7));
    chk("full slots7", 256'(entry_valid), 256'(8'b1111_1011));
    set_enq(7'h70, 2'b11); step();
    chk("refill slots", 256'(entry_valid), 256'(8'hFF));
    chk("refill robid", 256'(deq_robid), 256'(7'h70));

    // Reset mid-stream drops everything immediately
    set_enq(7'h71, 2'b11);
    reset_n = 0; #1;
    chk("midrst count", 256'(count), 256'(0));
    chk("midrst deq_valid", 256'(deq_valid), 256'(0));
    chk("midrst entry_valid", 256'(entry_valid), 256'(0));
    step();
    reset_n = 1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
